// File: rtl/ram_bank_sel.sv
// ram_bank_sel: registered RAM bank-select sequencer.
// Accepts a start address and beat count, then drives one one-hot bank select
// per enabled cycle, auto-incrementing the address with optional wrap-around.
module ram_bank_sel #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic                   req_wrap,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] sel,
  output logic                   sel_valid,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   trunc
);

  localparam int unsigned SEL_W = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              ready_q, ready_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              done_q, done_d;
  logic              trunc_q, trunc_d;

  logic              cut_c;
  logic              last_c;

  // A burst is cut short when it reaches the top address with beats left and no wrap.
  assign cut_c  = !wrap_q && (addr_q == TOP_ADDR) && (cnt_q != '0);
  assign last_c = (cnt_q == '0) || cut_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    ready_d     = ready_q;
    sel_d       = '0;
    sel_valid_d = 1'b0;
    cur_addr_d  = cur_addr_q;
    done_d      = 1'b0;
    trunc_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          wrap_d  = req_wrap;
          ready_d = 1'b0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (en) begin
          sel_d       = SEL_W'(1) << addr_q;
          sel_valid_d = 1'b1;
          cur_addr_d  = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - LEN_W'(1);
          if (last_c) begin
            done_d  = 1'b1;
            trunc_d = cut_c;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      ready_q     <= 1'b0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      cur_addr_q  <= '0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      cur_addr_q  <= cur_addr_d;
      done_q      <= done_d;
      trunc_q     <= trunc_d;
    end
  end

  assign req_ready = ready_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign cur_addr  = cur_addr_q;
  assign busy      = (state_q == BURST);
  assign done      = done_q;
  assign trunc     = trunc_q;

endmodule

// File: tb/tb_ram_bank_sel.sv
// Directed testbench for ram_bank_sel (ADDR_W=4, LEN_W=4).
module tb_ram_bank_sel;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic        req_wrap;
  logic        en;
  logic [15:0] sel;
  logic        sel_valid;
  logic [3:0]  cur_addr;
  logic        busy;
  logic        done;
  logic        trunc;

  int n_checks;
  int n_errors;

  ram_bank_sel #(.ADDR_W(4), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wrap  (req_wrap),
    .en        (en),
    .sel       (sel),
    .sel_valid (sel_valid),
    .cur_addr  (cur_addr),
    .busy      (busy),
    .done      (done),
    .trunc     (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full beat-output set in one go.
  task automatic check_beat(input string tag, input logic [15:0] e_sel, input logic e_sv,
                            input logic [3:0] e_addr, input logic e_done, input logic e_trunc);
    check({tag, ".sel"}, 32'(sel), 32'(e_sel));
    check({tag, ".sel_valid"}, 32'(sel_valid), 32'(e_sv));
    check({tag, ".cur_addr"}, 32'(cur_addr), 32'(e_addr));
    check({tag, ".done"}, 32'(done), 32'(e_done));
    check({tag, ".trunc"}, 32'(trunc), 32'(e_trunc));
  endtask

  // Present a request for one edge, then verify it was taken.
  task automatic send(input logic [3:0] a, input logic [3:0] l, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_wrap  = w;
    tick();
    req_valid = 1'b0;
    check("accept.busy", 32'(busy), 32'd1);
    check("accept.req_ready", 32'(req_ready), 32'd0);
  endtask

  initial begin
    logic [15:0] wrap_seq [4];
    wrap_seq[0] = 16'h4000;
    wrap_seq[1] = 16'h8000;
    wrap_seq[2] = 16'h0001;
    wrap_seq[3] = 16'h0002;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wrap  = 1'b0;
    en        = 1'b1;

    // Reset state
    #12;
    check("reset.outs", {8'(sel_valid), 8'(busy), 8'(done), 8'(trunc)}, 32'd0);
    check("reset.sel", 32'(sel), 32'd0);
    check("reset.ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset.ready", 32'(req_ready), 32'd1);
    check("post_reset.busy", 32'(busy), 32'd0);

    // Single beat
    send(4'd3, 4'd0, 1'b1);
    tick();
    check_beat("single", 16'h0008, 1'b1, 4'd3, 1'b1, 1'b0);
    check("single.busy", 32'(busy), 32'd0);
    check("single.ready", 32'(req_ready), 32'd1);
    tick();
    check_beat("single_after", 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0);

    // Wrap burst
    send(4'd14, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_beat($sformatf("wrap%0d", i), wrap_seq[i], 1'b1, 4'(14 + i), 1'(i == 3), 1'b0);
    end
    check("wrap.busy", 32'(busy), 32'd0);
    tick();

    // Truncation at the top address
    send(4'd14, 4'd3, 1'b0);
    tick();
    check_beat("trunc0", 16'h4000, 1'b1, 4'd14, 1'b0, 1'b0);
    tick();
    check_beat("trunc1", 16'h8000, 1'b1, 4'd15, 1'b1, 1'b1);
    check("trunc.busy", 32'(busy), 32'd0);
    check("trunc.ready", 32'(req_ready), 32'd1);
    tick();
    check_beat("trunc_after", 16'h0000, 1'b0, 4'd15, 1'b0, 1'b0);

    // Stall with en low for two cycles after beat 1
    send(4'd0, 4'd3, 1'b1);
    tick();
    check_beat("stall_b0", 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check_beat("stall_b1", 16'h0002, 1'b1, 4'd1, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    check_beat("stall_s0", 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0);
    check("stall_s0.busy", 32'(busy), 32'd1);
    tick();
    check_beat("stall_s1", 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    check_beat("stall_b2", 16'h0004, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    check_beat("stall_b3", 16'h0008, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();

    // Reset mid-burst
    send(4'd5, 4'd7, 1'b1);
    tick();
    check_beat("rst_b0", 16'h0020, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    check_beat("rst_b1", 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_beat("rst_async", 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_async.busy", 32'(busy), 32'd0);
    check("rst_async.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_rel.ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_idle%0d.sel_valid", i), 32'(sel_valid), 32'd0);
      check($sformatf("rst_idle%0d.busy", i), 32'(busy), 32'd0);
      tick();
    end

    // Back-to-back requests with req_valid held high
    req_valid = 1'b1;
    req_addr  = 4'd1;
    req_len   = 4'd1;
    req_wrap  = 1'b1;
    tick();
    check("b2b.accept_busy", 32'(busy), 32'd1);
    req_addr = 4'd8;
    req_len  = 4'd0;
    tick();
    check_beat("b2b_a0", 16'h0002, 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    check_beat("b2b_a1", 16'h0004, 1'b1, 4'd2, 1'b1, 1'b0);
    check("b2b_a1.ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_beat("b2b_gap", 16'h0000, 1'b0, 4'd2, 1'b0, 1'b0);
    check("b2b_gap.busy", 32'(busy), 32'd1);
    tick();
    check_beat("b2b_b0", 16'h0100, 1'b1, 4'd8, 1'b1, 1'b0);
    tick();
    check_beat("b2b_end", 16'h0000, 1'b0, 4'd8, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_bank_sel.md
# ram_bank_sel

Parametrised, registered RAM bank-select sequencer, the next generation of the combinational 4-to-16 enable decoder. It accepts a start address and beat count through a valid/ready handshake and drives one one-hot bank-select word per beat. The address auto-increments each beat, with optional wrap-around. It sits between the RAM access controller and the bank enables of the RAM array.

## Interface
Parameters:
- ADDR_W, 4: address width; select bus width is 2**ADDR_W
- LEN_W, 4: burst-length field width; maximum burst is 2**LEN_W beats

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (registered)
- req_addr  in  ADDR_W  start bank address
- req_len  in  LEN_W  beats minus one (0 means 1 beat)
- req_wrap  in  1  1: address wraps 2**ADDR_W-1 to 0; 0: burst truncates at top address
- en  in  1  global enable; 0 stalls the burst
- sel  out  2**ADDR_W  one-hot bank select, bit cur_addr set (registered)
- sel_valid  out  1  sel carries a beat this cycle
- cur_addr  out  ADDR_W  address of the current beat
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse with the last beat
- trunc  out  1  one-cycle pulse with done when the burst was cut at the top address

## Operation
- Reset is asynchronous and active-high. While rst=1, all outputs are 0: sel, sel_valid, cur_addr, busy, done, trunc, req_ready. The state is IDLE.
- FSM states:
  - IDLE: busy=0. req_ready rises to 1 on the first clk edge after rst deasserts. It stays 1 in IDLE.
  - BURST: busy=1.
- IDLE to BURST: at an edge with req_valid=1 and req_ready=1.
  - Capture the internal address from req_addr and the beat counter from req_len.
  - Capture the wrap mode from req_wrap.
  - Clear req_ready.
  - en does not gate acceptance.
- BURST, edge with en=1: issue one beat.
  - sel = 1<<addr, sel_valid=1, cur_addr=addr.
  - The address increments modulo 2**ADDR_W. The counter decrements.
- BURST, edge with en=0: sel=0 and sel_valid=0. Address and counter hold. done and trunc stay 0.
- Last beat is either of:
  - counter==0, or
  - req_wrap=0 and addr==2**ADDR_W-1 with counter>0. This is the truncated case: trunc=1.
- On the last-beat edge:
  - done=1 (with trunc as applicable).
  - Go to IDLE: busy=0, req_ready=1.
- Outside beat edges:
  - sel_valid, done and trunc return to 0 on the next edge.
  - sel returns to 0.
  - cur_addr holds its last value.
- Width rules:
  - sel has exactly one bit set when sel_valid=1, and is all zero otherwise.
  - With req_wrap=1, a burst of length 2**LEN_W can revisit addresses.

## Timing
- Request accepted at edge T.
  - Beat 0 outputs appear after edge T+1 if en=1 at T+1.
  - Beat i appears after edge T+1+i when en stays high.
- done is coincident with the last sel_valid.
  - req_ready is 1 in that same cycle.
  - A new request is accepted at the following edge.
  - Back-to-back bursts therefore have exactly one idle cycle (sel_valid=0) between them.
- Each en=0 cycle during BURST inserts exactly one stall cycle. No beat is lost or repeated.
- rst asserted mid-burst clears all outputs immediately, without waiting for a clk edge, and discards the burst. After rst deasserts, req_ready=1 after the first edge. No stale beats are issued.
- req_valid while req_ready=0 is ignored. Inputs are sampled only at the acceptance edge.

## Test plan
- Single beat: addr=3, len=0, wrap=1, en=1.
  - Expect sel=16'h0008, sel_valid=1, cur_addr=3, done=1, trunc=0 after the edge following acceptance.
  - Expect busy=0 and req_ready=1 in that same cycle.
- Wrap burst: addr=14, len=3, wrap=1.
  - Expect sel sequence 16'h4000, 16'h8000, 16'h0001, 16'h0002 on consecutive cycles.
  - Expect done only on the 4th beat, with trunc=0.
- Truncation: addr=14, len=3, wrap=0.
  - Expect sel 16'h4000, then 16'h8000.
  - Expect done=1 and trunc=1 on the 2nd beat, then IDLE.
- Stall: addr=0, len=3, en=0 for the 2 cycles after beat 1.
  - Expect beats 0x0001, 0x0002, then 2 cycles of sel=0 and sel_valid=0, then 0x0004, 0x0008 with done.
- Reset mid-burst: assert rst asynchronously during beat 1 of addr=5, len=7.
  - Expect all outputs 0 immediately.
  - Expect req_ready=1 one edge after release, and no beats until a new request.
- Back-to-back: req_valid held high with addr=1, len=1, then addr=8, len=0.
  - Expect 0x0002, 0x0004 (done), one cycle with sel_valid=0, then 0x0100 (done).
